// File: rtl/tcam_pkg.sv
// Shared TCAM definitions: group size, default geometry and a constant clog2
// used to size index ports across the search and update paths.
package tcam_pkg;

    localparam int TCAM_GRP = 8;
    localparam int TCAM_D   = 64;
    localparam int TCAM_W   = 32;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << result) < value) begin
                result = result + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/prio_enc8.sv
// Combinational lowest-set-bit encoder for one bank of match lines,
// with any-hit and more-than-one-hit flags.
module prio_enc8
    import tcam_pkg::*;
(
    input  logic [TCAM_GRP-1:0]        bits,
    output logic                       hit,
    output logic [clog2(TCAM_GRP)-1:0] idx,
    output logic                       multi
);

    localparam int LW = clog2(TCAM_GRP);

    // NOTE: every output gets a default before the scan so no latch is inferred.
    always_comb begin
        idx = '0;
        for (int i = TCAM_GRP - 1; i >= 0; i--) begin
            if (bits[i]) begin
                idx = LW'(i);
            end
        end
        hit   = |bits;
        multi = |(bits & (bits - TCAM_GRP'(1)));
    end

endmodule

// File: rtl/match_encoder.sv
// Two-stage priority encoder over the TCAM match lines: per-bank encode,
// then a lowest-bank-first merge, with saturating lookup/hit statistics.
module match_encoder
    import tcam_pkg::*;
#(
    parameter int  D  = TCAM_D,
    parameter int  CW = 32,
    localparam int IW = clog2(D)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [D-1:0]  match,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          hit,
    output logic [IW-1:0] hit_idx,
    output logic          multi_hit,
    input  logic          stat_clear,
    output logic [CW-1:0] lookup_cnt,
    output logic [CW-1:0] hit_cnt
);

    localparam int NG = D / TCAM_GRP;
    localparam int LW = clog2(TCAM_GRP);

    logic [NG-1:0] enc_hit;
    logic [NG-1:0] enc_multi;
    logic [LW-1:0] enc_idx [NG];

    logic [NG-1:0] grp_hit_q,   grp_hit_d;
    logic [NG-1:0] grp_multi_q, grp_multi_d;
    logic [LW-1:0] grp_idx_q [NG];
    logic [LW-1:0] grp_idx_d [NG];
    logic          s1_valid_q,  s1_valid_d;

    logic          out_valid_q, out_valid_d;
    logic          hit_q,       hit_d;
    logic [IW-1:0] hit_idx_q,   hit_idx_d;
    logic          multi_q,     multi_d;

    logic [CW-1:0] lookup_cnt_q, lookup_cnt_d;
    logic [CW-1:0] hit_cnt_q,    hit_cnt_d;

    logic          adv;
    logic          fire;
    logic          scan_found;
    logic          scan_multi;
    logic [IW-1:0] scan_idx;

    for (genvar g = 0; g < NG; g++) begin : g_enc
        prio_enc8 u_enc (
            .bits  (match[g*TCAM_GRP +: TCAM_GRP]),
            .hit   (enc_hit[g]),
            .idx   (enc_idx[g]),
            .multi (enc_multi[g])
        );
    end

    // Both stages move together; a stalled output freezes the whole pipe.
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;
    assign fire     = out_valid_q && out_ready;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        grp_hit_d   = grp_hit_q;
        grp_multi_d = grp_multi_q;
        grp_idx_d   = grp_idx_q;
        if (adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                grp_hit_d   = enc_hit;
                grp_multi_d = enc_multi;
                grp_idx_d   = enc_idx;
            end
        end
    end

    // First hitting bank wins; a second hitting bank means a multi-hit.
    always_comb begin
        scan_found = 1'b0;
        scan_multi = |grp_multi_q;
        scan_idx   = '0;
        for (int g = 0; g < NG; g++) begin
            if (grp_hit_q[g]) begin
                if (scan_found) begin
                    scan_multi = 1'b1;
                end else begin
                    scan_found = 1'b1;
                    scan_idx   = IW'(g * TCAM_GRP + int'(grp_idx_q[g]));
                end
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        hit_d       = hit_q;
        hit_idx_d   = hit_idx_q;
        multi_d     = multi_q;
        if (adv) begin
            out_valid_d = s1_valid_q;
            hit_d       = scan_found;
            hit_idx_d   = scan_idx;
            multi_d     = scan_multi;
        end
    end

    always_comb begin
        lookup_cnt_d = lookup_cnt_q;
        hit_cnt_d    = hit_cnt_q;
        if (stat_clear) begin
            lookup_cnt_d = '0;
            hit_cnt_d    = '0;
        end else if (fire) begin
            if (lookup_cnt_q != '1) begin
                lookup_cnt_d = lookup_cnt_q + CW'(1);
            end
            if (hit_q && hit_cnt_q != '1) begin
                hit_cnt_d = hit_cnt_q + CW'(1);
            end
        end
    end

    // NOTE: reset is synchronous, and all state updates use non-blocking assignments.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            grp_hit_q    <= '0;
            grp_multi_q  <= '0;
            for (int g = 0; g < NG; g++) begin
                grp_idx_q[g] <= '0;
            end
            out_valid_q  <= 1'b0;
            hit_q        <= 1'b0;
            hit_idx_q    <= '0;
            multi_q      <= 1'b0;
            lookup_cnt_q <= '0;
            hit_cnt_q    <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            grp_hit_q    <= grp_hit_d;
            grp_multi_q  <= grp_multi_d;
            grp_idx_q    <= grp_idx_d;
            out_valid_q  <= out_valid_d;
            hit_q        <= hit_d;
            hit_idx_q    <= hit_idx_d;
            multi_q      <= multi_d;
            lookup_cnt_q <= lookup_cnt_d;
            hit_cnt_q    <= hit_cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign hit        = hit_q;
    assign hit_idx    = hit_idx_q;
    assign multi_hit  = multi_q;
    assign lookup_cnt = lookup_cnt_q;
    assign hit_cnt    = hit_cnt_q;

endmodule

// File: tb/tb_match_encoder.sv
// Scoreboard bench for match_encoder: directed vectors push expected results,
// a negedge monitor pops and compares every output handshake.
module tb_match_encoder;

    typedef struct packed {
        logic       hit;
        logic [5:0] idx;
        logic       multi;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [63:0] match;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic        hit;
    logic [5:0]  hit_idx;
    logic        multi_hit;
    logic        stat_clear;
    logic [31:0] lookup_cnt;
    logic [31:0] hit_cnt;

    logic [63:0] s_match;
    logic        s_in_valid;
    logic        s_in_ready;
    logic        s_out_valid;
    logic        s_out_ready;
    logic        s_hit;
    logic [5:0]  s_hit_idx;
    logic        s_multi_hit;
    logic        s_stat_clear;
    logic [1:0]  s_lookup_cnt;
    logic [1:0]  s_hit_cnt;

    int   n_checks;
    int   n_errors;
    exp_t sb_q[$];

    match_encoder #(.D(64), .CW(32)) dut (
        .clk(clk), .reset(reset), .match(match), .in_valid(in_valid),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .hit(hit), .hit_idx(hit_idx), .multi_hit(multi_hit),
        .stat_clear(stat_clear), .lookup_cnt(lookup_cnt), .hit_cnt(hit_cnt)
    );

    match_encoder #(.D(64), .CW(2)) dut_sat (
        .clk(clk), .reset(reset), .match(s_match), .in_valid(s_in_valid),
        .in_ready(s_in_ready), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .hit(s_hit), .hit_idx(s_hit_idx), .multi_hit(s_multi_hit),
        .stat_clear(s_stat_clear), .lookup_cnt(s_lookup_cnt), .hit_cnt(s_hit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one vector and queue its hand-computed result once it is accepted.
    task automatic send(input logic [63:0] m, input logic eh, input logic [5:0] ei, input logic em);
        bit   acc;
        exp_t e;
        match    = m;
        in_valid = 1'b1;
        acc      = 1'b0;
        for (int k = 0; k < 32 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            step();
        end
        if (acc) begin
            e.hit   = eh;
            e.idx   = ei;
            e.multi = em;
            sb_q.push_back(e);
        end else begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: vector %0h not accepted in 32 cycles", m);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && sb_q.size() != 0; k++) begin
            step();
        end
        check("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    // Output monitor: scoreboard compare, stall stability and counter model.
    initial begin
        logic [31:0] exp_lookup;
        logic [31:0] exp_hitc;
        logic        prev_stall;
        logic [7:0]  held;
        exp_t        e;
        exp_lookup = '0;
        exp_hitc   = '0;
        prev_stall = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_lookup = '0;
                exp_hitc   = '0;
                prev_stall = 1'b0;
            end else begin
                check("lookup_cnt_model", 64'(lookup_cnt), 64'(exp_lookup));
                check("hit_cnt_model", 64'(hit_cnt), 64'(exp_hitc));
                if (prev_stall && out_valid) begin
                    check("stall_hold", 64'({hit, hit_idx, multi_hit}), 64'(held));
                end
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_output: hit_idx %0d emitted, none expected", hit_idx);
                    end else begin
                        e = sb_q.pop_front();
                        check("hit", 64'(hit), 64'(e.hit));
                        check("hit_idx", 64'(hit_idx), 64'(e.idx));
                        check("multi_hit", 64'(multi_hit), 64'(e.multi));
                    end
                end
                if (stat_clear) begin
                    exp_lookup = '0;
                    exp_hitc   = '0;
                end else if (out_valid && out_ready) begin
                    exp_lookup = exp_lookup + 32'd1;
                    if (hit) begin
                        exp_hitc = exp_hitc + 32'd1;
                    end
                end
                prev_stall = out_valid && !out_ready;
                held       = {hit, hit_idx, multi_hit};
            end
        end
    end

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        reset        = 1'b1;
        match        = '0;
        in_valid     = 1'b0;
        out_ready    = 1'b1;
        stat_clear   = 1'b0;
        s_match      = '0;
        s_in_valid   = 1'b0;
        s_out_ready  = 1'b1;
        s_stat_clear = 1'b0;

        step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_hit", 64'(hit), 64'd0);
        check("rst_hit_idx", 64'(hit_idx), 64'd0);
        check("rst_multi_hit", 64'(multi_hit), 64'd0);
        check("rst_lookup_cnt", 64'(lookup_cnt), 64'd0);
        check("rst_hit_cnt", 64'(hit_cnt), 64'd0);
        check("rst_sat_lookup_cnt", 64'(s_lookup_cnt), 64'd0);
        step();
        reset = 1'b0;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Single hit on rule 37, then verify latency and first counter step.
        send(64'd1 << 37, 1'b1, 6'd37, 1'b0);
        in_valid = 1'b0;
        step();
        check("t1_out_valid", 64'(out_valid), 64'd1);
        check("t1_hit", 64'(hit), 64'd1);
        check("t1_hit_idx", 64'(hit_idx), 64'd37);
        check("t1_multi_hit", 64'(multi_hit), 64'd0);
        step();
        check("t1_lookup_cnt", 64'(lookup_cnt), 64'd1);
        check("t1_hit_cnt", 64'(hit_cnt), 64'd1);

        // Priority, intra/inter-group multi-hit, miss and edge rules.
        send(64'h8000_0000_0000_1020, 1'b1, 6'd5,  1'b1);
        send(64'h0000_0000_0000_0600, 1'b1, 6'd9,  1'b1);
        send(64'h0000_0000_0000_0000, 1'b0, 6'd0,  1'b0);
        send(64'h8000_0000_0000_0000, 1'b1, 6'd63, 1'b0);
        send(64'h0000_0000_0000_0001, 1'b1, 6'd0,  1'b0);
        send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 6'd0,  1'b1);
        send(64'h0000_0000_0001_0100, 1'b1, 6'd8,  1'b1);
        in_valid = 1'b0;
        drain();
        step();
        check("dir_lookup_cnt", 64'(lookup_cnt), 64'd8);
        check("dir_hit_cnt", 64'(hit_cnt), 64'd7);

        // Stream rules 0..7 with a 4-cycle output stall mid-stream.
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(64'd1 << i, 1'b1, 6'(i), 1'b0);
                end
                in_valid = 1'b0;
            end
            begin
                repeat (3) step();
                out_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    check("stall_in_ready", 64'(in_ready), 64'd0);
                end
                step();
                out_ready = 1'b1;
            end
        join
        drain();
        step();
        check("bp_lookup_cnt", 64'(lookup_cnt), 64'd16);
        check("bp_hit_cnt", 64'(hit_cnt), 64'd15);

        // Reset with both stages full: neither result may ever appear.
        send(64'd1 << 3, 1'b1, 6'd3, 1'b0);
        send(64'd1 << 4, 1'b1, 6'd4, 1'b0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b1;
        sb_q.delete();
        step();
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_lookup_cnt", 64'(lookup_cnt), 64'd0);
        check("mid_rst_hit_cnt", 64'(hit_cnt), 64'd0);
        reset     = 1'b0;
        out_ready = 1'b1;
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        repeat (6) step();
        check("mid_rst_no_output", 64'(out_valid), 64'd0);

        // Two-bit counters: saturate at 3, then clear beats a same-cycle handshake.
        s_match    = 64'd1 << 20;
        s_in_valid = 1'b1;
        repeat (4) step();
        check("sat_lookup_2", 64'(s_lookup_cnt), 64'd2);
        check("sat_hit_2", 64'(s_hit_cnt), 64'd2);
        repeat (4) step();
        check("sat_lookup_hold", 64'(s_lookup_cnt), 64'd3);
        check("sat_hit_hold", 64'(s_hit_cnt), 64'd3);
        check("sat_handshake_live", 64'(s_out_valid && s_out_ready), 64'd1);
        s_stat_clear = 1'b1;
        step();
        check("clr_lookup", 64'(s_lookup_cnt), 64'd0);
        check("clr_hit", 64'(s_hit_cnt), 64'd0);
        s_stat_clear = 1'b0;
        step();
        check("clr_resume_lookup", 64'(s_lookup_cnt), 64'd1);
        check("clr_resume_hit", 64'(s_hit_cnt), 64'd1);
        s_in_valid = 1'b0;
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
